pipeline_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage rv32i pipeline (IF/ID/EX/MEM/WB).
- Generates the load and flush strobes that drive every stage register, including the control-word registers, plus the PC load and redirect selection.
- Resolves d-cache stalls, i-cache stalls, load-use hazards and taken-branch redirects.
- Holds a pending redirect across an outstanding i-fetch and keeps stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall, flush and redirect control for the 5-stage rv32i pipeline
module pipeline_hazard_ctrl #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic                 ex_br_taken,
  input  logic [XLEN-1:0]      ex_br_target,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_mem_read,
  output logic                 pc_load,
  output logic                 pc_redirect_sel,
  output logic [XLEN-1:0]      pc_redirect_target,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_flush,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, REDIR_WAIT = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [XLEN-1:0] target_q;
  logic            mem_stall, load_use, redirect_accept;

  assign mem_stall = dmem_req & ~dmem_resp;
  assign load_use  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  // A redirect is only taken once the d-cache stall has cleared.
  assign redirect_accept = (state == RUN) & ~mem_stall & ex_br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      target_q <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_accept && !imem_resp)
        target_q <= ex_br_target;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:        if (redirect_accept && !imem_resp) state_nxt = REDIR_WAIT;
      REDIR_WAIT: if (!mem_stall && imem_resp)       state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_load            = 1'b1;
    pc_redirect_sel    = 1'b0;
    pc_redirect_target = (state == REDIR_WAIT) ? target_q : ex_br_target;
    if_id_load         = 1'b1;
    id_ex_load         = 1'b1;
    ex_mem_load        = 1'b1;
    mem_wb_load        = 1'b1;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    ex_mem_flush       = 1'b0;
    mem_wb_flush       = 1'b0;
    if (rst) begin
      pc_load            = 1'b0;
      pc_redirect_target = '0;
      if_id_load         = 1'b0;
      id_ex_load         = 1'b0;
      ex_mem_load        = 1'b0;
      mem_wb_load        = 1'b0;
      if_id_flush        = 1'b1;
      id_ex_flush        = 1'b1;
      ex_mem_flush       = 1'b1;
      mem_wb_flush       = 1'b1;
    end else if (mem_stall) begin
      // Freeze front of the pipe; MEM/WB gets a bubble while the access is outstanding.
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (state == REDIR_WAIT || ex_br_taken) begin
      // Squash IF/ID and ID/EX; PC only moves once the outstanding fetch has returned.
      pc_load         = imem_resp;
      pc_redirect_sel = imem_resp;
      if_id_load      = 1'b0;
      id_ex_load      = 1'b0;
      if_id_flush     = 1'b1;
      id_ex_flush     = 1'b1;
    end else if (load_use) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!imem_resp) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_load)
        stall_cycles <= stall_cycles + CNT_ONE;
      if (redirect_accept)
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed-vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_resp, dmem_req, dmem_resp, ex_br_taken;
  logic [31:0] ex_br_target;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic        pc_load, pc_redirect_sel;
  logic [31:0] pc_redirect_target;
  logic        if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [31:0] stall_cycles, flush_count;

  int checks = 0;
  int failures = 0;

  // {pc_load, sel, if_id/id_ex/ex_mem/mem_wb load, if_id/id_ex/ex_mem/mem_wb flush}
  localparam logic [9:0] P_RESET = 10'b00_0000_1111;
  localparam logic [9:0] P_NORM  = 10'b10_1111_0000;
  localparam logic [9:0] P_LU    = 10'b00_0011_0100;
  localparam logic [9:0] P_IMISS = 10'b00_0111_1000;
  localparam logic [9:0] P_REDIR = 10'b11_0011_1100;
  localparam logic [9:0] P_RWAIT = 10'b00_0011_1100;
  localparam logic [9:0] P_MSTL  = 10'b00_0000_0001;

  wire [9:0] outs = {pc_load, pc_redirect_sel, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  pipeline_hazard_ctrl #(.XLEN(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .pc_load(pc_load), .pc_redirect_sel(pc_redirect_sel), .pc_redirect_target(pc_redirect_target),
    .if_id_load(if_id_load), .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load),
    .mem_wb_load(mem_wb_load), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are already applied just after a rising edge; sample mid-cycle, then advance.
  task automatic cyc(input string tag, input logic [9:0] exp);
    #2;
    check(tag, {54'd0, outs}, {54'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0; ex_br_taken = 1'b0;
    ex_br_target = 32'h0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    @(posedge clk); #1;
    #2;
    check("reset_outs", {54'd0, outs}, {54'd0, P_RESET});
    check("reset_target", pc_redirect_target, 32'h0);
    @(posedge clk); #1;
    check("reset_stall", stall_cycles, 32'd0);
    check("reset_flush", flush_count, 32'd0);

    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc("normal", P_NORM);
    check("normal_stall", stall_cycles, 32'd0);
    check("normal_flush", flush_count, 32'd0);

    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    cyc("lu_rs1", P_LU);
    check("lu_stall", stall_cycles, 32'd1);
    ex_rd = 5'd0; id_rs1 = 5'd0;
    cyc("lu_x0", P_NORM);
    check("lu_x0_stall", stall_cycles, 32'd1);
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; imem_resp = 1'b0;
    cyc("lu_rs2_imiss", P_LU);
    id_uses_rs2 = 1'b0;
    cyc("imiss_only", P_IMISS);
    check("imiss_stall", stall_cycles, 32'd3);

    quiet();
    ex_br_taken = 1'b1; ex_br_target = 32'h60;
    #2;
    check("redir_target", pc_redirect_target, 32'h60);
    #0 cyc("redir_now", P_REDIR);
    check("redir_flush", flush_count, 32'd1);
    ex_br_taken = 1'b0;
    cyc("redir_run", P_NORM);

    ex_br_taken = 1'b1; ex_br_target = 32'h80; imem_resp = 1'b0;
    cyc("pend_1", P_RWAIT);
    ex_br_target = 32'h99;
    cyc("pend_2", P_RWAIT);
    cyc("pend_3", P_RWAIT);
    check("pend_stall", stall_cycles, 32'd6);
    imem_resp = 1'b1;
    #2;
    check("pend_target", pc_redirect_target, 32'h80);
    #0 cyc("pend_ret", P_REDIR);
    check("pend_flush", flush_count, 32'd2);
    ex_br_taken = 1'b0;
    cyc("pend_run", P_NORM);
    check("pend_stall2", stall_cycles, 32'd6);

    ex_br_taken = 1'b1; ex_br_target = 32'h40; dmem_req = 1'b1; dmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mstall", P_MSTL);
    check("mstall_flush", flush_count, 32'd2);
    check("mstall_stall", stall_cycles, 32'd10);
    dmem_resp = 1'b1;
    cyc("mstall_redir", P_REDIR);
    check("mstall_redir_flush", flush_count, 32'd3);

    dmem_req = 1'b0; dmem_resp = 1'b0; imem_resp = 1'b0; ex_br_target = 32'h44;
    cyc("wait_enter", P_RWAIT);
    check("wait_flush", flush_count, 32'd4);
    rst = 1'b1; ex_br_taken = 1'b0;
    #2;
    check("rst_wait_target", pc_redirect_target, 32'h0);
    #0 cyc("rst_wait_outs", P_RESET);
    check("rst_wait_stall", stall_cycles, 32'd0);
    check("rst_wait_flush", flush_count, 32'd0);
    rst = 1'b0; imem_resp = 1'b1;
    cyc("post_rst_normal", P_NORM);
    check("post_rst_stall", stall_cycles, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
